lsu_subword: RTL and testbench
==============================

// Module: lsu_subword
// PURPOSE
//  Load/store unit between the single-cycle MIPS datapath and the word-only data memory.
//  Adds byte and halfword loads (signed and unsigned) and byte and halfword stores.
//  Sub-word stores use a 2-cycle read-modify-write, because the data memory writes whole
//  words only. Misaligned accesses are flagged and suppressed.
// PARAMETERS
//  BIG_ENDIAN  1  1: byte offset 0 = bits[31:24] (MIPS BE); 0: offset 0 = bits[7:0]
// PORTS
//  clk          in   1   clock; all state updates on posedge
//  reset_n      in   1   asynchronous, active-low reset
//  cpu_req      in   1   memory instruction valid this cycle
//  cpu_we       in   1   1=store, 0=load
//  cpu_size     in   2   00=byte, 01=half, 10=word, 11=reserved (treated as word)
//  cpu_signed   in   1   loads: 1=sign-extend, 0=zero-extend
//  cpu_addr     in   32  byte address
//  cpu_wdata    in   32  store data, right-justified (sub-word in low bits)
//  cpu_rdata    out  32  load result, extended to 32 bits
//  cpu_stall    out  1   1=hold PC/pipeline; CPU keeps all cpu_* stable
//  cpu_misalign out  1   alignment fault on the current request
//  mem_we       out  1   data-memory write enable
//  mem_addr     out  32  data-memory address; low 2 bits forced to 00
//  mem_wdata    out  32  data-memory write word
//  mem_rdata    in   32  data-memory read word (combinational read of mem_addr)
// BEHAVIOUR
//  Reset: state=IDLE; sav_addr, sav_word, sav_data, sav_size = 0.
//  - In reset: cpu_stall=0, mem_we=0, cpu_misalign=0.
//  - Reset is async and may assert at any time, including during MERGE.
//  - A reset in MERGE aborts the store; no write occurs.
//  Misalign, combinational:
//  - cpu_misalign = cpu_req & ((size==half & addr[0]) | (size==word/11 & addr[1:0]!=0)).
//  - Byte accesses never fault.
//  - On a fault: mem_we=0, cpu_stall=0, cpu_rdata=0, state unchanged.
//  Loads, combinational, 0 latency, no stall:
//  - mem_addr = {cpu_addr[31:2], 2'b00}; the selected byte/half is extracted from
//    mem_rdata using addr[1:0] and BIG_ENDIAN.
//  - The result is extended per cpu_signed; a word load passes mem_rdata through.
//  - cpu_rdata is also driven when cpu_req=0; the value is don't-care.
//  Word store: in IDLE, mem_we=1 and mem_wdata=cpu_wdata in the same cycle. No stall.
//  Sub-word store FSM (IDLE, MERGE):
//  IDLE, sub-word store request without fault:
//  - Drive cpu_stall=1, mem_we=0, mem_addr from cpu_addr.
//  - On posedge, capture sav_word=mem_rdata, sav_addr, sav_data, sav_size; go to MERGE.
//  MERGE:
//  - mem_addr={sav_addr[31:2],00}, mem_we=1, cpu_stall=0.
//  - mem_wdata = sav_word with the target byte/half replaced by sav_data low bits.
//  - Unselected bytes are bit-identical to sav_word.
//  - cpu_* inputs are ignored; the CPU is still presenting the same instruction.
//  - On posedge, go to IDLE unconditionally.
//  Timing and ordering:
//  - Sub-word store latency is 2 cycles, with exactly one stall cycle.
//  - Back-to-back sub-word stores to the same word merge correctly, because the 2nd
//    store's IDLE read follows the 1st store's MERGE write edge.
//  - cpu_req=0 in IDLE: mem_we=0, cpu_stall=0, no state change.
//  - mem_we is never asserted in IDLE for a sub-word store.
// TESTING
//  1 reset_n=0 mid-MERGE (sb pending) -> mem_we drops immediately; word unchanged; IDLE.
//  2 mem[0x10]=0x11223344, BE:
//    - lb 0x11 -> 0x00000022.
//    - lb 0x13 (signed, word 0x112233F4) -> 0xFFFFFFF4.
//    - lhu 0x12 -> 0x00003344.
//  3 BE sb 0x000000AB to 0x12, word 0x11223344:
//    - cycle0 stall=1, we=0.
//    - cycle1 we=1, wdata=0x1122AB44.
//    - Readback lw=0x1122AB44.
//  4 sh 0xBEEF to 0x10, then sb 0x77 to 0x13, back-to-back -> final word 0xBEEF3377.
//    Exactly 2 stall cycles in total.
//  5 lh at 0x11, sw at 0x12 -> misalign=1, mem_we=0, stall=0, memory unchanged.
//    sb at 0x13 -> no fault.
//  6 sw 0xDEADBEEF to 0x20 -> mem_we=1 same cycle, no stall.
//    BIG_ENDIAN=0: lbu 0x20 -> 0x000000EF.

Source files
------------

// File: rtl/lsu_subword.sv
// lsu_subword
//  Load/store unit sitting between a single-cycle MIPS datapath and a data
//  memory that can only read and write whole words.
//  - Loads (byte/half/word, signed or unsigned) complete combinationally with
//    no stall. The addressed byte or half is extracted from mem_rdata and then
//    sign- or zero-extended.
//  - Word stores write memory in the same cycle.
//  - Byte and half stores use a read-modify-write over two cycles:
//      IDLE  : stall the CPU, read the word, capture it and the store operands
//      MERGE : write back the word with only the target lane replaced
//  - Misaligned halves and words are flagged on cpu_misalign. They do not
//    stall, do not write, and return zero.
//
// Ports
//  clk, reset_n      clock (posedge) and asynchronous active-low reset
//  cpu_req/we/size   request valid, 1=store, size 00=byte 01=half 1x=word
//  cpu_signed        sign-extend loads
//  cpu_addr/wdata    byte address and right-justified store data
//  cpu_rdata         extended load result
//  cpu_stall         hold the pipeline (CPU keeps cpu_* stable while high)
//  cpu_misalign      alignment fault on the current request
//  mem_we/addr/wdata word-aligned data-memory write port
//  mem_rdata         combinational read of mem_addr
//  dbg_state         current FSM state (0=IDLE, 1=MERGE)
//
// Handshake: this interface has no valid/ready pair. A request is accepted in
//  any cycle where cpu_req=1 and cpu_stall=0. While cpu_stall=1 the CPU must
//  hold the same request, and it completes on the following cycle.
module lsu_subword #(
  parameter bit BIG_ENDIAN = 1'b1
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        cpu_req,
  input  logic        cpu_we,
  input  logic [1:0]  cpu_size,
  input  logic        cpu_signed,
  input  logic [31:0] cpu_addr,
  input  logic [31:0] cpu_wdata,
  output logic [31:0] cpu_rdata,
  output logic        cpu_stall,
  output logic        cpu_misalign,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  input  logic [31:0] mem_rdata,
  output logic        dbg_state
);

  typedef enum logic {
    IDLE  = 1'b0,
    MERGE = 1'b1
  } state_t;

  state_t      state, state_nx;
  logic [31:0] sav_addr, sav_word, sav_data;
  logic [1:0]  sav_size;
  logic        capture;

  logic        is_half, is_word;
  logic [4:0]  ld_shift, mg_shift;
  logic [31:0] ld_raw, mg_mask, mg_word;

  // Bit position of the lane's least significant bit within the word.
  // Big-endian puts offset 0 in the top byte, so the lane index is inverted.
  function automatic logic [4:0] lane_shift(input logic [1:0] size,
                                            input logic [1:0] off);
    logic [4:0] s;
    if (size[1])
      s = 5'd0;
    else if (size == 2'b00)
      s = BIG_ENDIAN ? {~off, 3'b000} : {off, 3'b000};
    else
      s = BIG_ENDIAN ? {~off[1], 4'b0000} : {off[1], 4'b0000};
    return s;
  endfunction

  assign is_half = (cpu_size == 2'b01);
  assign is_word = cpu_size[1];

  assign cpu_misalign = reset_n & cpu_req &
                        ((is_half & cpu_addr[0]) |
                         (is_word & (cpu_addr[1:0] != 2'b00)));

  assign dbg_state = state;

  // Load path. For word accesses the shift is zero, so ld_raw is mem_rdata.
  always_comb begin
    ld_shift = lane_shift(cpu_size, cpu_addr[1:0]);
    ld_raw   = mem_rdata >> ld_shift;
    case (cpu_size)
      2'b00:   cpu_rdata = {{24{cpu_signed & ld_raw[7]}}, ld_raw[7:0]};
      2'b01:   cpu_rdata = {{16{cpu_signed & ld_raw[15]}}, ld_raw[15:0]};
      default: cpu_rdata = ld_raw;
    endcase
    if (cpu_misalign)
      cpu_rdata = 32'd0;
  end

  // Merge path. Unselected lanes come from sav_word untouched.
  always_comb begin
    mg_shift = lane_shift(sav_size, sav_addr[1:0]);
    mg_mask  = ((sav_size == 2'b00) ? 32'h0000_00FF : 32'h0000_FFFF) << mg_shift;
    mg_word  = (sav_word & ~mg_mask) | ((sav_data << mg_shift) & mg_mask);
  end

  // Next state and memory/stall outputs
  always_comb begin
    state_nx  = state;
    cpu_stall = 1'b0;
    mem_we    = 1'b0;
    mem_addr  = {cpu_addr[31:2], 2'b00};
    mem_wdata = cpu_wdata;
    capture   = 1'b0;
    case (state)
      IDLE: begin
        if (cpu_req && cpu_we && !cpu_misalign) begin
          if (is_word) begin
            mem_we = 1'b1;
          end else begin
            cpu_stall = 1'b1;
            capture   = 1'b1;
            state_nx  = MERGE;
          end
        end
      end
      MERGE: begin
        mem_addr  = {sav_addr[31:2], 2'b00};
        mem_we    = 1'b1;
        mem_wdata = mg_word;
        state_nx  = IDLE;
      end
      default: state_nx = IDLE;
    endcase
    // Reset can arrive asynchronously in MERGE. Gating here makes the pending
    // write drop at once, before the state register has been cleared.
    if (!reset_n) begin
      cpu_stall = 1'b0;
      mem_we    = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state    <= IDLE;
      sav_addr <= 32'd0;
      sav_word <= 32'd0;
      sav_data <= 32'd0;
      sav_size <= 2'd0;
    end else begin
      state <= state_nx;
      if (capture) begin
        sav_word <= mem_rdata;
        sav_addr <= cpu_addr;
        sav_data <= cpu_wdata;
        sav_size <= cpu_size;
      end
    end
  end

endmodule

// File: tb/tb_lsu_subword.sv
module tb_lsu_subword;

  logic        clk;
  logic        reset_n;

  // big-endian instance, backed by a word memory
  logic        cpu_req, cpu_we, cpu_signed;
  logic [1:0]  cpu_size;
  logic [31:0] cpu_addr, cpu_wdata;
  logic [31:0] cpu_rdata, mem_addr, mem_wdata, mem_rdata;
  logic        cpu_stall, cpu_misalign, mem_we, dbg_state;

  // little-endian instance, loads only, memory word driven directly
  logic        le_req, le_signed;
  logic [1:0]  le_size;
  logic [31:0] le_addr, le_word;
  logic [31:0] le_rdata, le_mem_addr, le_mem_wdata;
  logic        le_stall, le_mis, le_mem_we, le_state;

  lsu_subword #(.BIG_ENDIAN(1'b1)) dut (
    .clk(clk), .reset_n(reset_n),
    .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_size(cpu_size),
    .cpu_signed(cpu_signed), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
    .cpu_rdata(cpu_rdata), .cpu_stall(cpu_stall), .cpu_misalign(cpu_misalign),
    .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .dbg_state(dbg_state)
  );

  lsu_subword #(.BIG_ENDIAN(1'b0)) dut_le (
    .clk(clk), .reset_n(reset_n),
    .cpu_req(le_req), .cpu_we(1'b0), .cpu_size(le_size),
    .cpu_signed(le_signed), .cpu_addr(le_addr), .cpu_wdata(32'd0),
    .cpu_rdata(le_rdata), .cpu_stall(le_stall), .cpu_misalign(le_mis),
    .mem_we(le_mem_we), .mem_addr(le_mem_addr), .mem_wdata(le_mem_wdata),
    .mem_rdata(le_word), .dbg_state(le_state)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // data memory seen by the BE instance (64 words, indexed by addr[7:2])
  logic [31:0] dmem [0:63];
  assign mem_rdata = dmem[mem_addr[7:2]];
  always @(posedge clk) if (mem_we) dmem[mem_addr[7:2]] <= mem_wdata;

  // reference model: byte-addressed memory, big-endian word assembly
  logic [7:0] ref_b [0:255];

  function automatic logic [31:0] ref_word(input logic [7:0] a);
    logic [7:0] b;
    b = {a[7:2], 2'b00};
    return {ref_b[b], ref_b[b + 8'd1], ref_b[b + 8'd2], ref_b[b + 8'd3]};
  endfunction

  function automatic logic [31:0] ref_load(input logic [7:0] a, input logic [1:0] size,
                                           input logic sgn);
    logic [31:0] v;
    case (size)
      2'b00: begin
        v = {24'd0, ref_b[a]};
        if (sgn && v[7]) v = v - 32'd256;
      end
      2'b01: begin
        v = {16'd0, ref_b[a], ref_b[a + 8'd1]};
        if (sgn && v[15]) v = v - 32'd65536;
      end
      default: v = ref_word(a);
    endcase
    return v;
  endfunction

  task automatic ref_store(input logic [7:0] a, input logic [1:0] size, input logic [31:0] d);
    case (size)
      2'b00: ref_b[a] = d[7:0];
      2'b01: begin
        ref_b[a]        = d[15:8];
        ref_b[a + 8'd1] = d[7:0];
      end
      default: begin
        ref_b[a]        = d[31:24];
        ref_b[a + 8'd1] = d[23:16];
        ref_b[a + 8'd2] = d[15:8];
        ref_b[a + 8'd3] = d[7:0];
      end
    endcase
  endtask

  function automatic logic is_fault(input logic [7:0] a, input logic [1:0] size);
    return (size == 2'b01 && a[0]) || (size >= 2'd2 && a[1:0] != 2'b00);
  endfunction

  // scoreboard
  typedef struct packed {
    logic        stall;
    logic        we;
    logic        mis;
    logic        chk_addr;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic        chk_rdata;
    logic [31:0] rdata;
  } exp_t;

  typedef struct packed {
    logic        mis;
    logic [31:0] rdata;
  } le_exp_t;

  exp_t    exp_q[$];
  le_exp_t le_q[$];
  int      n_pass, n_total;
  int      exp_stalls, obs_stalls;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
  endtask

  // monitor: one expected record per driven cycle, compared mid-cycle
  exp_t    mon_e;
  le_exp_t mon_l;
  always @(negedge clk) begin
    if (reset_n && cpu_stall) obs_stalls++;
    if (exp_q.size() != 0) begin
      mon_e = exp_q.pop_front();
      chk("cpu_stall", {31'd0, cpu_stall}, {31'd0, mon_e.stall});
      chk("mem_we", {31'd0, mem_we}, {31'd0, mon_e.we});
      chk("cpu_misalign", {31'd0, cpu_misalign}, {31'd0, mon_e.mis});
      if (mon_e.chk_addr) chk("mem_addr", mem_addr, mon_e.addr);
      if (mon_e.we) chk("mem_wdata", mem_wdata, mon_e.wdata);
      if (mon_e.chk_rdata) chk("cpu_rdata", cpu_rdata, mon_e.rdata);
    end
    if (le_q.size() != 0) begin
      mon_l = le_q.pop_front();
      chk("le_misalign", {31'd0, le_mis}, {31'd0, mon_l.mis});
      chk("le_rdata", le_rdata, mon_l.rdata);
    end
  end

  // driver: one operation on the BE instance
  task automatic do_op(input logic req, input logic we, input logic [1:0] size,
                       input logic sgn, input logic [31:0] addr, input logic [31:0] wdata);
    exp_t e, e2;
    logic [7:0] a;
    logic flt;
    @(posedge clk); #1;
    cpu_req = req; cpu_we = we; cpu_size = size; cpu_signed = sgn;
    cpu_addr = addr; cpu_wdata = wdata;
    a = addr[7:0];
    flt = req && is_fault(a, size);
    e = '0;
    e.mis  = flt;
    e.addr = {addr[31:2], 2'b00};
    if (!req) begin
      exp_q.push_back(e);
    end else if (flt) begin
      e.chk_addr = 1'b1; e.chk_rdata = 1'b1; e.rdata = 32'd0;
      exp_q.push_back(e);
    end else if (!we) begin
      e.chk_addr = 1'b1; e.chk_rdata = 1'b1; e.rdata = ref_load(a, size, sgn);
      exp_q.push_back(e);
    end else if (size >= 2'd2) begin
      e.chk_addr = 1'b1; e.we = 1'b1; e.wdata = wdata;
      ref_store(a, size, wdata);
      exp_q.push_back(e);
    end else begin
      e.chk_addr = 1'b1; e.stall = 1'b1;
      exp_q.push_back(e);
      exp_stalls++;
      ref_store(a, size, wdata);
      e2 = '0;
      e2.chk_addr = 1'b1; e2.addr = e.addr; e2.we = 1'b1; e2.wdata = ref_word(a);
      @(posedge clk); #1;
      exp_q.push_back(e2);
    end
  endtask

  task automatic le_load(input logic [31:0] word, input logic [31:0] addr,
                         input logic [1:0] size, input logic sgn);
    le_exp_t l;
    logic [31:0] v;
    @(posedge clk); #1;
    le_req = 1'b1; le_word = word; le_addr = addr; le_size = size; le_signed = sgn;
    // little-endian: byte at offset k is (word / 256^k) mod 256
    v = word >> (8 * addr[1:0]);
    case (size)
      2'b00: begin v = v & 32'hFF;   if (sgn && v[7])  v = v - 32'd256;   end
      2'b01: begin v = v & 32'hFFFF; if (sgn && v[15]) v = v - 32'd65536; end
      default: v = word;
    endcase
    l.mis = is_fault(addr[7:0], size);
    l.rdata = l.mis ? 32'd0 : v;
    le_q.push_back(l);
  endtask

  initial begin
    logic [31:0] ra, rd;
    n_pass = 0; n_total = 0; exp_stalls = 0; obs_stalls = 0;
    cpu_req = 0; cpu_we = 0; cpu_size = 0; cpu_signed = 0; cpu_addr = 0; cpu_wdata = 0;
    le_req = 0; le_signed = 0; le_size = 0; le_addr = 0; le_word = 0;
    reset_n = 1'b0;

    // reset state, with a word store presented to prove the outputs are held off
    repeat (2) @(posedge clk);
    #1;
    cpu_req = 1; cpu_we = 1; cpu_size = 2'b10; cpu_addr = 32'h10;
    #1;
    chk("reset_mem_we", {31'd0, mem_we}, 32'd0);
    chk("reset_stall", {31'd0, cpu_stall}, 32'd0);
    chk("reset_misalign", {31'd0, cpu_misalign}, 32'd0);
    chk("reset_state", {31'd0, dbg_state}, 32'd0);
    cpu_req = 0;
    @(negedge clk);
    reset_n = 1'b1;

    // initialise all of memory through word stores
    for (int i = 0; i < 64; i++) do_op(1, 1, 2'b10, 0, 32'(i * 4), $urandom());

    // BE loads from 0x11223344 at 0x10
    do_op(1, 1, 2'b10, 0, 32'h10, 32'h11223344);
    do_op(1, 0, 2'b00, 0, 32'h11, 32'h0);   // lb  -> 0x22
    do_op(1, 0, 2'b01, 0, 32'h12, 32'h0);   // lhu -> 0x3344
    do_op(1, 1, 2'b10, 0, 32'h10, 32'h112233F4);
    do_op(1, 0, 2'b00, 1, 32'h13, 32'h0);   // lb signed -> 0xFFFFFFF4

    // BE sb into 0x11223344
    do_op(1, 1, 2'b10, 0, 32'h10, 32'h11223344);
    do_op(1, 1, 2'b00, 0, 32'h12, 32'h000000AB);
    do_op(1, 0, 2'b10, 0, 32'h10, 32'h0);   // lw -> 0x1122AB44

    // back-to-back sh + sb to the same word
    do_op(1, 1, 2'b10, 0, 32'h10, 32'h11223344);
    do_op(1, 1, 2'b01, 0, 32'h10, 32'h0000BEEF);
    do_op(1, 1, 2'b00, 0, 32'h13, 32'h00000077);
    do_op(1, 0, 2'b10, 0, 32'h10, 32'h0);   // lw -> 0xBEEF3377

    // faults and their absence
    do_op(1, 0, 2'b01, 0, 32'h11, 32'h0);
    do_op(1, 1, 2'b10, 0, 32'h12, 32'hCAFEF00D);
    do_op(1, 1, 2'b01, 0, 32'h13, 32'h1234);
    do_op(1, 1, 2'b00, 0, 32'h13, 32'h55);
    do_op(1, 0, 2'b10, 0, 32'h10, 32'h0);

    // word store, then idle
    do_op(1, 1, 2'b10, 0, 32'h20, 32'hDEADBEEF);
    do_op(0, 0, 2'b00, 0, 32'h20, 32'h0);

    // reset during MERGE aborts the pending byte store
    do_op(1, 1, 2'b10, 0, 32'h30, 32'hA5A5A5A5);
    @(posedge clk); #1;
    cpu_req = 1; cpu_we = 1; cpu_size = 2'b00; cpu_addr = 32'h31; cpu_wdata = 32'h3C;
    exp_stalls++;
    @(posedge clk); #1;
    chk("merge_entered", {31'd0, dbg_state}, 32'd1);
    reset_n = 1'b0;
    #1;
    chk("abort_mem_we", {31'd0, mem_we}, 32'd0);
    chk("abort_stall", {31'd0, cpu_stall}, 32'd0);
    chk("abort_state", {31'd0, dbg_state}, 32'd0);
    cpu_req = 0;
    @(posedge clk);
    @(negedge clk);
    reset_n = 1'b1;
    do_op(1, 0, 2'b10, 0, 32'h30, 32'h0);   // still 0xA5A5A5A5

    // randomized mix
    for (int i = 0; i < 400; i++) begin
      ra = $urandom();
      rd = $urandom();
      if ($urandom_range(0, 9) == 0)
        do_op(0, 1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)), 0, ra, rd);
      else
        do_op(1, 1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)),
              1'($urandom_range(0, 1)), ra, rd);
    end
    @(posedge clk); #1;
    cpu_req = 0;

    // little-endian instance
    le_load(32'hDEADBEEF, 32'h20, 2'b00, 0);   // lbu -> 0xEF
    le_load(32'hDEADBEEF, 32'h22, 2'b01, 1);   // lh  -> 0xFFFFDEAD
    for (int i = 0; i < 60; i++)
      le_load($urandom(), $urandom(), 2'($urandom_range(0, 3)), 1'($urandom_range(0, 1)));
    @(posedge clk); #1;
    le_req = 0;
    repeat (2) @(posedge clk);

    chk("stall_count", 32'(obs_stalls), 32'(exp_stalls));
    for (int i = 0; i < 64; i++) chk("final_mem", dmem[i], ref_word(8'(i * 4)));
    chk("queues_drained", 32'(exp_q.size() + le_q.size()), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
